// File: rtl/wash_pkg.sv
// Shared types and constants for the washer phase timer.
// Holds the timer state enum and the clk_freq rate codes.
package wash_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tstate_e;

  localparam logic [1:0] FREQ_1M = 2'b00;
  localparam logic [1:0] FREQ_2M = 2'b01;
  localparam logic [1:0] FREQ_4M = 2'b10;
  localparam logic [1:0] FREQ_8M = 2'b11;

endpackage

// File: rtl/wash_timer_sec_tick_gen.sv
// Cycle prescaler: counts 0..limit, emits a one-cycle tick on wrap.
// Ports: clk, i_rst (sync, high), i_load (clear + latch i_limit),
//        i_en (count enable), i_limit (wrap value), o_tick.
module sec_tick_gen
  import wash_pkg::*;
#(
  parameter int CNT_W = 30
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_limit;
  logic             w_wrap;

  assign w_wrap = (r_cnt == r_limit);
  assign o_tick = i_en & w_wrap;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_limit <= '0;
    end else if (i_load) begin
      r_cnt   <= '0;
      r_limit <= i_limit;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wash_timer.sv
// Phase interval timer: counts BASE_SECONDS (x2 if double_time)
// seconds at the rate picked by clk_freq, then holds timer_finish.
// Ports: clk, rst_n (sync, active-high despite the name),
//        state_time (load strobe), timer_pause, double_time,
//        clk_freq[1:0], timer_finish (registered).
module wash_timer
  import wash_pkg::*;
#(
  parameter int CYCLES_PER_SEC = 1000000,
  parameter int BASE_SECONDS   = 60,
  parameter int CNT_W          = 30,
  parameter int SEC_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       state_time,
  input  logic       timer_pause,
  input  logic       double_time,
  input  logic [1:0] clk_freq,
  output logic       timer_finish
);

  tstate_e          r_state;
  tstate_e          w_state_nxt;
  logic [SEC_W-1:0] r_sec;
  logic [SEC_W-1:0] w_sec_nxt;
  logic [SEC_W-1:0] r_tgt;
  logic [SEC_W-1:0] w_tgt_nxt;
  logic             r_fin;
  logic             w_fin_nxt;

  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_limit;
  logic [SEC_W-1:0] w_tgt_ld;
  logic             w_en;
  logic             w_tick;

  assign w_base   = CNT_W'(CYCLES_PER_SEC);
  assign w_limit  = (w_base << clk_freq) - CNT_W'(1);
  assign w_tgt_ld = SEC_W'(BASE_SECONDS) << double_time;

  // Load wins over counting, so the prescaler never
  // advances on a load edge.
  assign w_en = (r_state == RUN) & ~timer_pause & ~state_time;

  sec_tick_gen #(
    .CNT_W(CNT_W)
  ) u_tick (
    .clk    (clk),
    .i_rst  (rst_n),
    .i_load (state_time),
    .i_en   (w_en),
    .i_limit(w_limit),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= IDLE;
      r_sec   <= '0;
      r_tgt   <= '0;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sec   <= w_sec_nxt;
      r_tgt   <= w_tgt_nxt;
      r_fin   <= w_fin_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sec_nxt   = r_sec;
    w_tgt_nxt   = r_tgt;
    w_fin_nxt   = r_fin;
    if (state_time) begin
      w_state_nxt = RUN;
      w_sec_nxt   = '0;
      w_tgt_nxt   = w_tgt_ld;
      w_fin_nxt   = 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_tick) begin
            // Last second: finish without bumping seconds
            // so the counter never exceeds target-1.
            if (r_sec == r_tgt - SEC_W'(1)) begin
              w_state_nxt = DONE;
              w_fin_nxt   = 1'b1;
            end else begin
              w_sec_nxt = r_sec + SEC_W'(1);
            end
          end
        end
        DONE:    w_fin_nxt = 1'b1;
        default: w_fin_nxt = 1'b0;
      endcase
    end
  end

  assign timer_finish = r_fin;

endmodule

// File: tb/tb_wash_timer.sv
// Scoreboard bench for wash_timer with CYCLES_PER_SEC=4,
// BASE_SECONDS=3 (12 / 96 edge intervals).
module tb_wash_timer;
  import wash_pkg::*;

  localparam int CPS  = 4;
  localparam int BASE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       state_time = 1'b0;
  logic       timer_pause = 1'b0;
  logic       double_time = 1'b0;
  logic [1:0] clk_freq = FREQ_1M;
  logic       timer_finish;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int exp_q[$];

  wash_timer #(
    .CYCLES_PER_SEC(CPS),
    .BASE_SECONDS  (BASE),
    .CNT_W         (30),
    .SEC_W         (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .state_time  (state_time),
    .timer_pause (timer_pause),
    .double_time (double_time),
    .clk_freq    (clk_freq),
    .timer_finish(timer_finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the interval in edges for given rate/double inputs.
  function automatic int interval(input logic [1:0] f,
                                  input logic d);
    return (BASE << d) * (CPS << f);
  endfunction

  // Load strobe held for n edges; returns cyc of last load edge.
  task automatic do_load(input int n, output int l);
    @(negedge clk);
    state_time = 1'b1;
    repeat (n) @(negedge clk);
    state_time = 1'b0;
    l = cyc;
  endtask

  // Waits for timer_finish=1 at a negedge; -1 on budget expiry.
  task automatic wait_rise(input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      if (timer_finish === 1'b1) begin
        c = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_rise(input string nm, input int budget);
    int c;
    int e;
    wait_rise(budget, c);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
    n_tests++;
    if (c !== e) begin
      n_fail++;
      $display("FAIL %s: rise at cyc %0d, expected %0d", nm, c, e);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    state_time = 1'b1;
    timer_pause = 1'b1;
    double_time = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (timer_finish !== 1'b0 || dut.r_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset: fin=%b st=%0d, expected 0/IDLE",
               timer_finish, dut.r_state);
    end
    rst_n = 1'b0;
    state_time = 1'b0;
    timer_pause = 1'b0;
    double_time = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (timer_finish !== 1'b0) begin
      n_fail++;
      $display("FAIL idle: fin=%b, expected 0", timer_finish);
    end
  endtask

  task automatic test_basic();
    int l;
    int held;
    clk_freq = FREQ_1M;
    double_time = 1'b0;
    do_load(1, l);
    exp_q.push_back(l + interval(FREQ_1M, 1'b0));
    check_rise("basic", 100);
    held = 1;
    repeat (22) begin
      @(negedge clk);
      if (timer_finish !== 1'b1) held = 0;
    end
    n_tests++;
    if (held !== 1) begin
      n_fail++;
      $display("FAIL basic_hold: held=%0d, expected 1", held);
    end
  endtask

  task automatic test_double_rate();
    int l;
    clk_freq = FREQ_4M;
    double_time = 1'b1;
    do_load(1, l);
    exp_q.push_back(l + 96);
    repeat (20) @(negedge clk);
    clk_freq = FREQ_1M;
    double_time = 1'b0;
    check_rise("double_rate", 200);
  endtask

  task automatic test_pause();
    int l;
    int r;
    clk_freq = FREQ_1M;
    double_time = 1'b0;
    do_load(1, l);
    exp_q.push_back(l + 22);
    while (cyc < l + 4) @(negedge clk);
    timer_pause = 1'b1;
    while (cyc < l + 14) @(negedge clk);
    timer_pause = 1'b0;
    check_rise("pause", 100);
    do_load(1, l);
    timer_pause = 1'b1;
    repeat (5) @(negedge clk);
    do_load(1, r);
    exp_q.push_back(r + 3 + 12);
    while (cyc < r + 3) @(negedge clk);
    timer_pause = 1'b0;
    check_rise("pause_reload", 100);
  endtask

  task automatic test_reload_hold();
    int l;
    int bad;
    bad = 0;
    @(negedge clk);
    state_time = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (timer_finish !== 1'b0) bad++;
    end
    state_time = 1'b0;
    l = cyc;
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hold: high cycles=%0d, expected 0", bad);
    end
    exp_q.push_back(l + 12);
    check_rise("hold_release", 100);
    repeat (4) @(negedge clk);
    do_load(1, l);
    n_tests++;
    if (timer_finish !== 1'b0) begin
      n_fail++;
      $display("FAIL done_reload: fin=%b, expected 0", timer_finish);
    end
    exp_q.push_back(l + 12);
    check_rise("done_reload", 100);
  endtask

  task automatic test_reset_midrun();
    int l;
    int c;
    do_load(1, l);
    while (cyc < l + 5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    n_tests++;
    if (timer_finish !== 1'b0 || dut.r_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid: fin=%b st=%0d, expected 0/IDLE",
               timer_finish, dut.r_state);
    end
    wait_rise(40, c);
    n_tests++;
    if (c !== -1) begin
      n_fail++;
      $display("FAIL reset_quiet: rise at %0d, expected none", c);
    end
  endtask

  task automatic test_back_to_back();
    int l;
    clk_freq = FREQ_2M;
    double_time = 1'b0;
    do_load(1, l);
    exp_q.push_back(l + interval(FREQ_2M, 1'b0));
    check_rise("rate_2m", 100);
    clk_freq = FREQ_8M;
    double_time = 1'b1;
    do_load(1, l);
    exp_q.push_back(l + 192);
    check_rise("rate_8m_dbl", 300);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_double_rate();
    test_pause();
    test_reload_hold();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wash_timer.md
Name:
wash_timer

Overview:
- Interval timer for the washing-machine controller.
- The controller strobes state_time at each phase entry. The block then counts a fixed interval in seconds, doubled when double_time is set.
- Seconds are derived from the system clock, whose frequency is selected by clk_freq.
- timer_finish tells the controller FSM that the phase has elapsed.

Parameters:
- CYCLES_PER_SEC, default 1000000: clock cycles per second at clk_freq=00 (1 MHz). Codes 01, 10 and 11 use 2x, 4x and 8x this value.
- BASE_SECONDS, default 60: interval length in seconds when double_time=0.
- CNT_W, default 30: width of the cycle prescaler. It must hold 8*CYCLES_PER_SEC-1.
- SEC_W, default 8: width of the seconds counter. It must hold 2*BASE_SECONDS-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset. One clock; reset is synchronous and active-high. The name rst_n is kept for codebase consistency; rst_n=1 resets the block.
- state_time  in  1  load/start strobe; level-sampled each cycle.
- timer_pause  in  1  1 = freeze counting while running.
- double_time  in  1  1 = interval is 2*BASE_SECONDS; sampled at load.
- clk_freq  in  2  clock-rate code 00/01/10/11 = 1/2/4/8 MHz; sampled at load.
- timer_finish  out  1  registered; 1 = interval elapsed.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_n=1 at a rising edge): state=IDLE, prescaler=0, seconds=0, timer_finish=0, latched target and rate cleared. Reset overrides all other inputs.
- Load (state_time=1 at an edge, any state, not in reset):
  - prescaler=0, seconds=0, timer_finish=0, state=RUN.
  - Latch target = BASE_SECONDS << double_time.
  - Latch limit = (CYCLES_PER_SEC << clk_freq) - 1.
  - Load has priority over timer_pause.
  - Holding state_time high keeps reloading, so no counting occurs.
- RUN, timer_pause=1, state_time=0: all registers hold.
- RUN, timer_pause=0, state_time=0:
  - If prescaler == limit: prescaler=0 and seconds increments.
  - Otherwise prescaler increments.
  - If prescaler == limit and seconds == target-1: state=DONE and timer_finish=1 on that same edge.
  - The interval is therefore exactly target*(limit+1) unpaused cycles after the load edge.
- DONE: timer_finish stays 1 and counters hold until the next load or reset. Pause has no effect.
- IDLE: timer_finish=0, counters hold at 0. Pause and double_time are ignored.
- Changes to clk_freq or double_time after the load edge do not affect the running interval.
- No wrap-around: counters never exceed their limits, because RUN exits to DONE.
- Reset mid-run: returns to IDLE, and timer_finish is 0 after the edge.

Decomposition:
- Shared package wash_pkg:
  - timer state enum {IDLE, RUN, DONE}.
  - clk_freq code constants FREQ_1M=2'b00, FREQ_2M=2'b01, FREQ_4M=2'b10, FREQ_8M=2'b11.
- One natural sub-module, sec_tick_gen: the prescaler (clear, enable, latched limit) that emits a one-cycle sec_tick when it wraps.
- The top level holds the seconds counter, target latch and FSM.

Test Plan:
Benches use CYCLES_PER_SEC=4 and BASE_SECONDS=3.
- Reset: rst_n=1 for 2 cycles -> timer_finish=0 and state IDLE, regardless of other inputs.
- Basic interval: clk_freq=00, double_time=0, state_time=1 for one cycle, pause=0 -> timer_finish rises exactly 12 edges after the load edge and stays 1 for 20+ further cycles.
- Double time and rate: clk_freq=10, double_time=1, load -> limit=15 and target=6, so timer_finish rises 96 edges after the load edge. Toggling clk_freq and double_time mid-run has no effect.
- Pause: clk_freq=00, load, pause=1 for cycles 5..14 after load -> timer_finish rises at edge 22 instead of 12. state_time=1 while paused reloads the timer.
- Reload and hold: state_time held high for 10 cycles -> timer_finish stays 0. State_time asserted in DONE -> timer_finish=0 on the next edge, then rises again 12 edges later.
- Reset mid-run: assert rst_n=1 at edge 6 of a run -> timer_finish=0 and no assertion afterwards until a new load.
